// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the pipeline core (ibus/dbus), the arbiter and the
// shared memory port (cbus).
//
// Handshake: a requester raises x_valid with stable request fields and keeps
// them until x_data_ok. The arbiter presents c_valid with stable fields until
// the memory side returns c_ready; that cycle is the single completing beat.
// x_addr_ok and x_data_ok pulse together for exactly that one cycle.
interface mem_bus_arbiter_if;
    // instruction-fetch port
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;
    // data-access port
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [63:0] d_rdata;
    // shared memory port
    logic        c_valid;
    logic        c_is_write;
    logic [2:0]  c_size;
    logic [63:0] c_addr;
    logic [7:0]  c_strobe;
    logic [63:0] c_wdata;
    logic        c_ready;
    logic        c_last;
    logic [63:0] c_rdata;

    // arbiter view
    modport slave (
        input  i_valid, i_addr,
        output i_addr_ok, i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output c_valid, c_is_write, c_size, c_addr, c_strobe, c_wdata,
        input  c_ready, c_last, c_rdata
    );

    // core + memory view
    modport master (
        output i_valid, i_addr,
        input  i_addr_ok, i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  c_valid, c_is_write, c_size, c_addr, c_strobe, c_wdata,
        output c_ready, c_last, c_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter merging ibus and dbus onto one single-beat cbus.
// One transaction is outstanding at a time; the winner's request is
// registered so cbus fields never depend combinationally on the core.
// A sticky watchdog flags a transaction that stays busy too long.
module mem_bus_arbiter #(
    parameter bit D_PRIORITY = 1'b1,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output logic               err_timeout,
    output logic [1:0]         o_dbg_state,
    output logic               o_dbg_no_last
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_busy;
    logic              w_done_i;
    logic              w_done_d;

    logic              r_c_valid;
    logic              r_c_is_write;
    logic [2:0]        r_c_size;
    logic [63:0]       r_c_addr;
    logic [7:0]        r_c_strobe;
    logic [63:0]       r_c_wdata;
    logic              r_i_hi;

    logic [CNT_W-1:0]  r_wd_cnt;
    logic [CNT_W-1:0]  w_wd_inc;
    logic              r_err;

    // State register; reset drops any in-flight transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration in IDLE and completion on c_ready while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.d_valid && (!bus.i_valid || D_PRIORITY)) begin
                    w_state_nxt = ST_BUSY_D;
                    w_grant_d   = 1'b1;
                end else if (bus.i_valid) begin
                    w_state_nxt = ST_BUSY_I;
                    w_grant_i   = 1'b1;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // c_last is not consulted: every transaction is one beat.
                if (bus.c_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy   = (r_state != ST_IDLE);
    assign w_done_i = (r_state == ST_BUSY_I) && bus.c_ready;
    assign w_done_d = (r_state == ST_BUSY_D) && bus.c_ready;

    // Latch the winning request on the grant edge; clear c_valid on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_valid    <= 1'b0;
            r_c_is_write <= 1'b0;
            r_c_size     <= 3'd0;
            r_c_addr     <= 64'd0;
            r_c_strobe   <= 8'd0;
            r_c_wdata    <= 64'd0;
            r_i_hi       <= 1'b0;
        end else if (w_grant_d) begin
            r_c_valid    <= 1'b1;
            r_c_is_write <= |bus.d_strobe;
            r_c_size     <= bus.d_size;
            r_c_addr     <= bus.d_addr;
            r_c_strobe   <= bus.d_strobe;
            r_c_wdata    <= bus.d_wdata;
        end else if (w_grant_i) begin
            // instruction fetch is always a 4-byte read
            r_c_valid    <= 1'b1;
            r_c_is_write <= 1'b0;
            r_c_size     <= 3'd2;
            r_c_addr     <= bus.i_addr;
            r_c_strobe   <= 8'd0;
            r_c_wdata    <= 64'd0;
            r_i_hi       <= bus.i_addr[2];
        end else if (w_done_i || w_done_d) begin
            r_c_valid    <= 1'b0;
        end
    end

    assign w_wd_inc = (r_wd_cnt == {CNT_W{1'b1}}) ? r_wd_cnt : r_wd_cnt + CNT_W'(1);

    // Watchdog counter: cleared on entry to busy, counts busy cycles without c_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_wd_cnt <= '0;
        end else if (w_busy && !bus.c_ready) begin
            r_wd_cnt <= w_wd_inc;
        end
    end

    // Sticky error: set on the same edge the counter reaches TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((TIMEOUT != 0) && w_busy && !bus.c_ready && (w_wd_inc == TO_VAL)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.c_valid    = r_c_valid;
    assign bus.c_is_write = r_c_is_write;
    assign bus.c_size     = r_c_size;
    assign bus.c_addr     = r_c_addr;
    assign bus.c_strobe   = r_c_strobe;
    assign bus.c_wdata    = r_c_wdata;

    // Response routing; data is forced to zero outside the completing cycle.
    assign bus.i_addr_ok  = w_done_i;
    assign bus.i_data_ok  = w_done_i;
    assign bus.i_data     = w_done_i ? (r_i_hi ? bus.c_rdata[63:32] : bus.c_rdata[31:0]) : 32'd0;
    assign bus.d_addr_ok  = w_done_d;
    assign bus.d_data_ok  = w_done_d;
    assign bus.d_rdata    = w_done_d ? bus.c_rdata : 64'd0;

    assign err_timeout    = r_err;
    assign o_dbg_state    = r_state;
    // flags a completing beat that arrived without c_last
    assign o_dbg_no_last  = (w_done_i || w_done_d) && !bus.c_last;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with dbus priority and a
// short watchdog, one with ibus priority for the arbitration-order case.
module tb_mem_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       err1, err0;
    logic [1:0] st1, st0;
    logic       nl1, nl0;
    int         checks;
    int         errors;

    mem_bus_arbiter_if bus1 ();
    mem_bus_arbiter_if bus0 ();

    mem_bus_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT(8), .CNT_W(16)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus1.slave),
        .err_timeout   (err1),
        .o_dbg_state   (st1),
        .o_dbg_no_last (nl1)
    );

    mem_bus_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT(8), .CNT_W(16)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus0.slave),
        .err_timeout   (err0),
        .o_dbg_state   (st0),
        .o_dbg_no_last (nl0)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.i_valid = 1'b0; bus1.i_addr = '0; bus1.d_valid = 1'b0; bus1.d_addr = '0;
        bus1.d_size = '0; bus1.d_strobe = '0; bus1.d_wdata = '0;
        bus1.c_ready = 1'b0; bus1.c_last = 1'b1; bus1.c_rdata = '0;
        bus0.i_valid = 1'b0; bus0.i_addr = '0; bus0.d_valid = 1'b0; bus0.d_addr = '0;
        bus0.d_size = '0; bus0.d_strobe = '0; bus0.d_wdata = '0;
        bus0.c_ready = 1'b0; bus0.c_last = 1'b1; bus0.c_rdata = '0;

        // ---- reset state
        settle();
        chk("rst_c_valid", bus1.c_valid, 0);
        chk("rst_c_addr", bus1.c_addr, 0);
        chk("rst_state", st1, 0);
        chk("rst_err", err1, 0);
        chk("rst_i_ok", bus1.i_addr_ok, 0);
        chk("rst_d_rdata", bus1.d_rdata, 0);
        tick();
        tick();
        reset = 1'b0;

        // ---- ibus only, memory replies two cycles after c_valid
        bus1.i_valid = 1'b1;
        bus1.i_addr  = 64'h0000_0000_8000_0004;
        settle();
        chk("ib_cvalid_req_cycle", bus1.c_valid, 0);
        tick();
        chk("ib_cvalid", bus1.c_valid, 1);
        chk("ib_caddr", bus1.c_addr, 64'h8000_0004);
        chk("ib_csize", bus1.c_size, 2);
        chk("ib_cwrite", bus1.c_is_write, 0);
        chk("ib_cstrobe", bus1.c_strobe, 0);
        chk("ib_state", st1, 1);
        chk("ib_ok_early", bus1.i_data_ok, 0);
        tick();
        chk("ib_hold_cvalid", bus1.c_valid, 1);
        chk("ib_hold_addr", bus1.c_addr, 64'h8000_0004);
        tick();
        bus1.c_ready = 1'b1;
        bus1.c_rdata = 64'h1111_2222_3333_4444;
        settle();
        chk("ib_addr_ok", bus1.i_addr_ok, 1);
        chk("ib_data_ok", bus1.i_data_ok, 1);
        chk("ib_data", bus1.i_data, 32'h1111_2222);
        chk("ib_d_ok", bus1.d_data_ok, 0);
        tick();
        bus1.i_valid = 1'b0;
        bus1.c_ready = 1'b0;
        settle();
        chk("ib_ok_pulse", bus1.i_data_ok, 0);
        chk("ib_cvalid_drop", bus1.c_valid, 0);
        chk("ib_idle", st1, 0);

        // ---- c_ready in IDLE is ignored
        bus1.c_ready = 1'b1;
        settle();
        chk("idle_rdy_i_ok", bus1.i_data_ok, 0);
        chk("idle_rdy_d_ok", bus1.d_data_ok, 0);
        tick();
        chk("idle_rdy_state", st1, 0);
        bus1.c_ready = 1'b0;

        // ---- simultaneous requests, dbus priority
        bus1.d_valid  = 1'b1;
        bus1.d_addr   = 64'h8000_1000;
        bus1.d_size   = 3'd3;
        bus1.d_strobe = 8'hFF;
        bus1.d_wdata  = 64'hDEAD_BEEF_0000_0001;
        bus1.i_valid  = 1'b1;
        bus1.i_addr   = 64'h8000_0008;
        tick();
        chk("p1_state_d", st1, 2);
        chk("p1_cwrite", bus1.c_is_write, 1);
        chk("p1_caddr", bus1.c_addr, 64'h8000_1000);
        chk("p1_cwdata", bus1.c_wdata, 64'hDEAD_BEEF_0000_0001);
        chk("p1_cstrobe", bus1.c_strobe, 8'hFF);
        chk("p1_csize", bus1.c_size, 3);
        chk("p1_i_ok_busy", bus1.i_addr_ok, 0);
        tick();
        bus1.c_ready = 1'b1;
        settle();
        chk("p1_d_addr_ok", bus1.d_addr_ok, 1);
        chk("p1_d_data_ok", bus1.d_data_ok, 1);
        chk("p1_i_ok_dcomp", bus1.i_data_ok, 0);
        tick();
        bus1.d_valid  = 1'b0;
        bus1.d_strobe = 8'h00;
        bus1.c_ready  = 1'b0;
        settle();
        chk("p1_gap_state", st1, 0);
        chk("p1_gap_cvalid", bus1.c_valid, 0);
        chk("p1_gap_i_ok", bus1.i_data_ok, 0);
        tick();
        chk("p1_state_i", st1, 1);
        chk("p1_i_caddr", bus1.c_addr, 64'h8000_0008);
        chk("p1_i_cwrite", bus1.c_is_write, 0);
        bus1.c_ready = 1'b1;
        bus1.c_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        chk("p1_i_data_ok", bus1.i_data_ok, 1);
        chk("p1_i_data_lo", bus1.i_data, 32'hCCCC_DDDD);
        tick();
        bus1.i_valid = 1'b0;
        bus1.c_ready = 1'b0;
        settle();
        chk("p1_end_state", st1, 0);

        // ---- same stimulus, ibus priority
        bus0.d_valid  = 1'b1;
        bus0.d_addr   = 64'h8000_1000;
        bus0.d_size   = 3'd3;
        bus0.d_strobe = 8'hFF;
        bus0.d_wdata  = 64'hDEAD_BEEF_0000_0001;
        bus0.i_valid  = 1'b1;
        bus0.i_addr   = 64'h8000_0008;
        tick();
        chk("p0_state_i", st0, 1);
        chk("p0_caddr_i", bus0.c_addr, 64'h8000_0008);
        chk("p0_cwrite_i", bus0.c_is_write, 0);
        bus0.c_ready = 1'b1;
        bus0.c_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        chk("p0_i_data_ok", bus0.i_data_ok, 1);
        chk("p0_i_data", bus0.i_data, 32'hCCCC_DDDD);
        chk("p0_d_ok_icomp", bus0.d_addr_ok, 0);
        tick();
        bus0.i_valid = 1'b0;
        bus0.c_ready = 1'b0;
        settle();
        chk("p0_gap_state", st0, 0);
        tick();
        chk("p0_state_d", st0, 2);
        chk("p0_cwrite_d", bus0.c_is_write, 1);
        chk("p0_caddr_d", bus0.c_addr, 64'h8000_1000);
        chk("p0_cwdata_d", bus0.c_wdata, 64'hDEAD_BEEF_0000_0001);
        bus0.c_ready = 1'b1;
        settle();
        chk("p0_d_data_ok", bus0.d_data_ok, 1);
        chk("p0_i_ok_dcomp", bus0.i_data_ok, 0);
        tick();
        bus0.d_valid = 1'b0;
        bus0.c_ready = 1'b0;
        settle();
        chk("p0_end_state", st0, 0);

        // ---- dbus byte read; requester drops valid while busy, c_last=0
        bus1.d_valid  = 1'b1;
        bus1.d_addr   = 64'h8000_0003;
        bus1.d_size   = 3'd0;
        bus1.d_strobe = 8'h00;
        tick();
        chk("br_cwrite", bus1.c_is_write, 0);
        chk("br_csize", bus1.c_size, 0);
        chk("br_cstrobe", bus1.c_strobe, 0);
        chk("br_caddr", bus1.c_addr, 64'h8000_0003);
        bus1.d_valid = 1'b0;
        tick();
        chk("br_hold_state", st1, 2);
        bus1.c_ready = 1'b1;
        bus1.c_last  = 1'b0;
        bus1.c_rdata = 64'h0123_4567_89AB_CDEF;
        settle();
        chk("br_d_data_ok", bus1.d_data_ok, 1);
        chk("br_d_rdata", bus1.d_rdata, 64'h0123_4567_89AB_CDEF);
        chk("br_no_last", nl1, 1);
        tick();
        bus1.c_ready = 1'b0;
        bus1.c_last  = 1'b1;
        settle();
        chk("br_end_state", st1, 0);
        chk("br_end_ok", bus1.d_data_ok, 0);

        // ---- watchdog, TIMEOUT=8
        bus1.d_valid = 1'b1;
        bus1.d_addr  = 64'h8000_2000;
        tick();
        chk("wd_busy1_err", err1, 0);
        for (int k = 2; k <= 8; k++) tick();
        chk("wd_busy8_err", err1, 0);
        tick();
        chk("wd_err_set", err1, 1);
        chk("wd_state_kept", st1, 2);
        chk("wd_cvalid_kept", bus1.c_valid, 1);
        bus1.c_ready = 1'b1;
        settle();
        chk("wd_d_data_ok", bus1.d_data_ok, 1);
        tick();
        bus1.d_valid = 1'b0;
        bus1.c_ready = 1'b0;
        settle();
        chk("wd_err_sticky", err1, 1);
        chk("wd_end_state", st1, 0);

        // ---- reset in the middle of a dbus transaction
        bus1.d_valid  = 1'b1;
        bus1.d_addr   = 64'h8000_3000;
        bus1.d_strobe = 8'h0F;
        tick();
        chk("rm_busy_state", st1, 2);
        chk("rm_busy_cvalid", bus1.c_valid, 1);
        settle();
        reset = 1'b1;
        settle();
        chk("rm_cvalid_drop", bus1.c_valid, 0);
        chk("rm_state_idle", st1, 0);
        chk("rm_err_clear", err1, 0);
        bus1.d_valid  = 1'b0;
        bus1.d_strobe = 8'h00;
        tick();
        reset = 1'b0;
        bus1.i_valid = 1'b1;
        bus1.i_addr  = 64'h8000_0004;
        tick();
        chk("rm_i_state", st1, 1);
        chk("rm_i_caddr", bus1.c_addr, 64'h8000_0004);
        bus1.c_ready = 1'b1;
        bus1.c_rdata = 64'h5555_6666_7777_8888;
        settle();
        chk("rm_i_data_ok", bus1.i_data_ok, 1);
        chk("rm_i_data", bus1.i_data, 32'h5555_6666);
        chk("rm_no_stale_d", bus1.d_data_ok, 0);
        tick();
        bus1.i_valid = 1'b0;
        bus1.c_ready = 1'b0;
        settle();
        chk("rm_end_state", st1, 0);
        chk("rm_end_d_ok", bus1.d_data_ok, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Sits directly downstream of the pipeline core. It merges the core's instruction-fetch port (ibus) and data-access port (dbus) onto the single shared memory port (cbus) toward the memory/cache side. It arbitrates between the two, registers the winning request, tracks one outstanding single-beat transaction, and routes the response back to the requester. A watchdog flags transactions that never complete.

Parameters:
D_PRIORITY, 1, 1 = dbus wins a simultaneous request; 0 = ibus wins.
TIMEOUT, 1024, cycles in a busy state before err_timeout sets; 0 disables the watchdog.
CNT_W, 16, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-high reset.
i_valid  in  1  ibus request valid; held by core until i_data_ok.
i_addr  in  64  fetch address, 4-byte aligned.
i_addr_ok  out  1  ibus address accepted.
i_data_ok  out  1  ibus data returned.
i_data  out  32  fetched instruction.
d_valid  in  1  dbus request valid; held until d_data_ok.
d_addr  in  64  data address.
d_size  in  3  log2 bytes (0=1B .. 3=8B).
d_strobe  in  8  byte write enables; 0 = read.
d_wdata  in  64  write data, lane-aligned.
d_addr_ok  out  1  dbus address accepted.
d_data_ok  out  1  dbus data returned or write done.
d_rdata  out  64  read data, lane-aligned.
c_valid  out  1  cbus request valid.
c_is_write  out  1  1 = write.
c_size  out  3  access size.
c_addr  out  64  access address.
c_strobe  out  8  write strobes.
c_wdata  out  64  write data.
c_ready  in  1  cbus beat complete.
c_last  in  1  last beat; always 1 for single-beat transactions.
c_rdata  in  64  cbus read data.
err_timeout  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset sets state IDLE, all c_* outputs 0, all *_ok outputs 0, i_data/d_rdata 0, err_timeout 0, and the counter 0.
- IDLE:
  - If only d_valid is high, go to BUSY_D.
  - If only i_valid is high, go to BUSY_I.
  - If both are high, D_PRIORITY picks the winner.
  - On the grant edge, latch the winner's request into registers.
  - ibus is granted as a read: size=2, strobe=0, is_write=0.
  - dbus sets is_write = |d_strobe.
- c_valid and the c_* fields are driven from the registers only. Latency: a request in IDLE at cycle N gives c_valid=1 at cycle N+1.
- BUSY_x: hold c_valid and all fields stable until c_ready.
  - In the c_ready cycle, x_addr_ok and x_data_ok are both 1, combinationally from c_ready. Each is a one-cycle pulse.
  - Next state is IDLE, with c_valid=0.
  - The minimum spacing between transactions is therefore one IDLE cycle.
- Response data:
  - d_rdata = c_rdata, passed through.
  - i_data = c_rdata[63:32] if latched addr[2]=1, else c_rdata[31:0].
  - Both are valid only while the corresponding data_ok is high.
- The *_ok outputs are 0 in every cycle except the completing one. The losing requester sees no ok until its own grant.
- Requester drops valid while busy: the transaction still completes downstream and the ok pulse is still produced. The arbiter never aborts a cbus transaction except on reset.
- A c_ready seen in IDLE is ignored, with no ok pulse. c_last=0 with c_ready=1 is treated identically to c_last=1.
- Fairness: with D_PRIORITY=1, a persistent d_valid may starve the ibus. This is accepted, because the core stalls fetch while memory is busy.
- Watchdog:
  - The counter clears on entry to BUSY_x and increments each busy cycle without c_ready, saturating at its maximum.
  - When the counter reaches TIMEOUT, err_timeout sets and stays set until reset.
  - It does not change the state.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronous). The pending request is dropped and c_valid falls without waiting for c_ready.

Test Plan:
- ibus only: i_valid=1, i_addr=0x8000_0004; memory replies c_ready=1 with c_rdata=0x1111_2222_3333_4444 two cycles after c_valid → c_valid rises 1 cycle after request with c_addr=0x8000_0004, c_size=2, c_is_write=0; i_data=0x1111_2222 and i_addr_ok=i_data_ok=1 for exactly 1 cycle.
- Simultaneous requests, D_PRIORITY=1: dbus write d_addr=0x8000_1000, d_strobe=0xFF, d_wdata=0xDEAD_BEEF_0000_0001 together with an ibus read → dbus is served first with c_is_write=1 and matching data; ibus is granted in the cycle after the dbus completion cycle (IDLE); no i_*_ok during the dbus transaction.
- Same stimulus with D_PRIORITY=0 → ibus served first, then dbus.
- dbus byte read: d_size=0, d_strobe=0, d_addr=0x8000_0003 → c_is_write=0, c_size=0, c_strobe=0; d_rdata equals c_rdata unmodified.
- Watchdog: TIMEOUT=8, c_ready held 0 → err_timeout=1 at the 8th busy cycle and stays 1 after c_ready later completes the transaction.
- Reset mid-transaction: assert reset while in BUSY_D with c_valid=1 → c_valid=0 and state IDLE immediately; after release a fresh ibus request completes normally with no stale d_data_ok.
